bullet_pool: RTL and testbench

//  Multi-slot projectile engine for the doodle: up to NUM_BULLETS bullets in flight at once,
//  per-direction velocity, frame-based fire cooldown and per-slot hit clearing.

---
 rtl/bullet_pool.sv | 180 ++++++++++++++++++
 tb/tb_bullet_pool.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// Multi-slot projectile engine: spawns, moves, retires and hit-clears doodle bullets
// and reports whether the current pixel lies on an active bullet.
module bullet_pool #(
  parameter int unsigned NUM_BULLETS = 4,
  parameter int unsigned BULLET_SIZE = 2,
  parameter int unsigned SPEED_X     = 4,
  parameter int unsigned SPEED_Y     = 11,
  parameter int unsigned COOLDOWN    = 3,
  parameter int unsigned X_MIN       = 160,
  parameter int unsigned X_MAX       = 479,
  parameter int unsigned Y_LIMIT     = 600
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_clk,
  input  logic                      shoot,
  input  logic [2:0]                direction,
  input  logic [NUM_BULLETS-1:0]    hit,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic [9:0]                Ball_X,
  input  logic [9:0]                Ball_Y,
  input  logic [9:0]                Ball_Size,
  output logic [10*NUM_BULLETS-1:0] bullet_x,
  output logic [10*NUM_BULLETS-1:0] bullet_y,
  output logic [NUM_BULLETS-1:0]    active,
  output logic                      is_bullet,
  output logic [2:0]                bullet_idx,
  output logic                      shot_fired,
  output logic                      shot_dropped
);

  localparam int unsigned CW       = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);
  localparam logic [9:0] SPD_X     = 10'(SPEED_X);
  localparam logic [9:0] SPD_Y     = 10'(SPEED_Y);
  localparam logic [9:0] VX_LEFT   = ~SPD_X + 10'd1;
  localparam logic [9:0] VY_UP     = ~SPD_Y + 10'd1;
  localparam logic [9:0] XMIN      = 10'(X_MIN);
  localparam logic [9:0] XMAX      = 10'(X_MAX);
  localparam logic [9:0] YLIM      = 10'(Y_LIMIT);
  localparam logic [9:0] Y_HIT     = 10'(Y_LIMIT + 1);
  localparam logic [9:0] BSIZE     = 10'(BULLET_SIZE);

  logic [9:0] pos_x [NUM_BULLETS];
  logic [9:0] pos_y [NUM_BULLETS];
  logic [9:0] vel_x [NUM_BULLETS];
  logic [9:0] vel_y [NUM_BULLETS];

  logic [CW-1:0]          cd;
  logic                   frame_q, frame_tick;
  logic                   shoot_q, shoot_edge;
  logic [NUM_BULLETS-1:0] free_slots;
  logic [NUM_BULLETS-1:0] spawn_oh;
  logic                   have_free;
  logic                   spawn_ok;
  logic [NUM_BULLETS-1:0] retire;
  logic [9:0]             spawn_vx;

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Rising-edge detection of the frame clock and shoot request
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q    <= 1'b0;
      frame_tick <= 1'b0;
      shoot_q    <= 1'b0;
      shoot_edge <= 1'b0;
    end else begin
      frame_q    <= frame_clk;
      frame_tick <= frame_clk & ~frame_q;
      shoot_q    <= shoot;
      shoot_edge <= shoot & ~shoot_q;
    end
  end

  // Lowest free slot; slots being hit this cycle are not offered
  always_comb begin
    free_slots = ~active & ~hit;
    spawn_oh   = '0;
    have_free  = 1'b0;
    for (int i = 0; i < int'(NUM_BULLETS); i++) begin
      if (free_slots[i] && !have_free) begin
        spawn_oh[i] = 1'b1;
        have_free   = 1'b1;
      end
    end
    spawn_ok = shoot_edge && (cd == '0) && have_free;
  end

  // Horizontal spawn velocity from the facing direction
  always_comb begin
    case (direction)
      3'd1:    spawn_vx = VX_LEFT;
      3'd3:    spawn_vx = SPD_X;
      default: spawn_vx = 10'd0;
    endcase
  end

  // Out-of-field detection on the registered position
  always_comb begin
    retire = '0;
    for (int i = 0; i < int'(NUM_BULLETS); i++) begin
      retire[i] = active[i] && ((pos_y[i] > YLIM) || (pos_x[i] < XMIN) || (pos_x[i] > XMAX));
    end
  end

  // Fire cooldown counter and spawn result pulses
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cd           <= '0;
      shot_fired   <= 1'b0;
      shot_dropped <= 1'b0;
    end else begin
      shot_fired   <= spawn_ok;
      shot_dropped <= shoot_edge && !spawn_ok;
      if (spawn_ok)
        cd <= CD_LOAD;
      else if (frame_tick && (cd != '0))
        cd <= cd - CW'(1);
    end
  end

  // Per-slot state: hit beats spawn beats retire beats move
  always_ff @(posedge Clk) begin
    if (Reset) begin
      active <= '0;
      for (int i = 0; i < int'(NUM_BULLETS); i++) begin
        pos_x[i] <= 10'd0;
        pos_y[i] <= 10'd0;
        vel_x[i] <= 10'd0;
        vel_y[i] <= 10'd0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_BULLETS); i++) begin
        if (hit[i]) begin
          active[i] <= 1'b0;
          pos_y[i]  <= Y_HIT;
        end else if (spawn_ok && spawn_oh[i]) begin
          active[i] <= 1'b1;
          pos_x[i]  <= Ball_X;
          pos_y[i]  <= Ball_Y - Ball_Size;
          vel_x[i]  <= spawn_vx;
          vel_y[i]  <= VY_UP;
        end else if (retire[i]) begin
          active[i] <= 1'b0;
        end else if (active[i] && frame_tick) begin
          pos_x[i] <= pos_x[i] + vel_x[i];
          pos_y[i] <= pos_y[i] + vel_y[i];
        end
      end
    end
  end

  // Flatten slot positions onto the output buses
  always_comb begin
    bullet_x = '0;
    bullet_y = '0;
    for (int i = 0; i < int'(NUM_BULLETS); i++) begin
      bullet_x[10*i +: 10] = pos_x[i];
      bullet_y[10*i +: 10] = pos_y[i];
    end
  end

  // Pixel coverage; scanned high to low so the lowest covering slot wins
  always_comb begin
    is_bullet  = 1'b0;
    bullet_idx = 3'd0;
    for (int i = int'(NUM_BULLETS) - 1; i >= 0; i--) begin
      if (active[i] && (abs_diff(DrawX, pos_x[i]) <= BSIZE) &&
          (abs_diff(DrawY, pos_y[i]) <= BSIZE)) begin
        is_bullet  = 1'b1;
        bullet_idx = 3'(i);
      end
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: stimulus queues expected pulses and state
// snapshots, a negedge monitor pops and compares them.
module tb_bullet_pool;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        shoot = 1'b0;
  logic [2:0]  direction = 3'd0;
  logic [3:0]  hit = 4'd0;
  logic [9:0]  DrawX = 10'd0, DrawY = 10'd0;
  logic [9:0]  Ball_X = 10'd0, Ball_Y = 10'd0, Ball_Size = 10'd0;
  logic [39:0] bullet_x, bullet_y;
  logic [3:0]  active;
  logic        is_bullet;
  logic [2:0]  bullet_idx;
  logic        shot_fired, shot_dropped;

  typedef struct {
    logic [3:0] act;
    int         slot;
    logic [9:0] x;
    logic [9:0] y;
    bit         chk_pix;
    logic       isb;
    logic [2:0] idx;
  } snap_t;

  bit    ev_q[$];
  snap_t snap_q[$];
  logic  snap_req = 1'b0;
  int    n_vec = 0;
  int    n_bad = 0;

  bullet_pool dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .shoot(shoot),
    .direction(direction), .hit(hit), .DrawX(DrawX), .DrawY(DrawY),
    .Ball_X(Ball_X), .Ball_Y(Ball_Y), .Ball_Size(Ball_Size),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .active(active),
    .is_bullet(is_bullet), .bullet_idx(bullet_idx),
    .shot_fired(shot_fired), .shot_dropped(shot_dropped)
  );

  always #5 Clk = ~Clk;

  // Monitor: pops an expected pulse whenever the DUT pulses, and a snapshot on request
  always @(negedge Clk) begin
    if (shot_fired || shot_dropped) begin
      n_vec++;
      if (ev_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: fired=%b dropped=%b, none expected", shot_fired, shot_dropped);
      end else begin
        bit e;
        e = ev_q.pop_front();
        if (shot_fired !== e || shot_dropped !== !e) begin
          n_bad++;
          $display("FAIL shot_pulse: fired=%b dropped=%b, required fired=%b dropped=%b",
                   shot_fired, shot_dropped, e, !e);
        end
      end
    end
    if (snap_req) begin
      snap_t s;
      logic [9:0] gx, gy;
      bit bad;
      n_vec++;
      bad = 1'b0;
      if (snap_q.size() == 0) begin
        bad = 1'b1;
        $display("FAIL snapshot: request with empty queue");
      end else begin
        s = snap_q.pop_front();
        if (active !== s.act) begin
          bad = 1'b1;
          $display("FAIL snap_active: got %b, required %b", active, s.act);
        end
        if (s.slot >= 0) begin
          gx = bullet_x[10*s.slot +: 10];
          gy = bullet_y[10*s.slot +: 10];
          if (gx !== s.x || gy !== s.y) begin
            bad = 1'b1;
            $display("FAIL snap_pos slot%0d: got (%0d,%0d), required (%0d,%0d)",
                     s.slot, gx, gy, s.x, s.y);
          end
        end
        if (s.chk_pix && (is_bullet !== s.isb || bullet_idx !== s.idx)) begin
          bad = 1'b1;
          $display("FAIL snap_pixel (%0d,%0d): got is_bullet=%b idx=%0d, required is_bullet=%b idx=%0d",
                   DrawX, DrawY, is_bullet, bullet_idx, s.isb, s.idx);
        end
      end
      if (bad) n_bad++;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // One frame-clock pulse; returns after the move and the following retire cycle
  task automatic tick(input int n = 1);
    repeat (n) begin
      frame_clk = 1'b1;
      cyc();
      frame_clk = 1'b0;
      cyc(2);
    end
  endtask

  task automatic fire(input bit expect_fired);
    ev_q.push_back(expect_fired);
    shoot = 1'b1;
    cyc();
    shoot = 1'b0;
    cyc(2);
  endtask

  task automatic snap(input logic [3:0] act, input int slot, input logic [9:0] x, input logic [9:0] y);
    snap_t s;
    s = '{act: act, slot: slot, x: x, y: y, chk_pix: 1'b0, isb: 1'b0, idx: 3'd0};
    snap_q.push_back(s);
    snap_req = 1'b1;
    cyc();
    snap_req = 1'b0;
  endtask

  task automatic snap_pix(input logic [9:0] dx, input logic [9:0] dy, input logic [3:0] act,
                          input logic isb, input logic [2:0] idx);
    snap_t s;
    DrawX = dx;
    DrawY = dy;
    s = '{act: act, slot: -1, x: 10'd0, y: 10'd0, chk_pix: 1'b1, isb: isb, idx: idx};
    snap_q.push_back(s);
    snap_req = 1'b1;
    cyc();
    snap_req = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    snap(4'b0000, 0, 10'd0, 10'd0);
    snap_pix(10'd0, 10'd0, 4'b0000, 1'b0, 3'd0);

    // Straight-up spawn and movement
    Ball_X = 10'd300; Ball_Y = 10'd400; Ball_Size = 10'd8; direction = 3'd0;
    fire(1'b1);
    snap(4'b0001, 0, 10'd300, 10'd392);
    tick(3);
    snap(4'b0001, 0, 10'd300, 10'd359);

    // Cooldown: refused one tick after a spawn, accepted after three
    fire(1'b1);
    snap(4'b0011, 1, 10'd300, 10'd392);
    tick();
    fire(1'b0);
    snap(4'b0011, 1, 10'd300, 10'd381);
    tick(2);
    fire(1'b1);
    snap(4'b0111, 2, 10'd300, 10'd392);
    snap(4'b0111, 0, 10'd300, 10'd326);

    // Pixel coverage around slots 1 and 2
    snap_pix(10'd300, 10'd360, 4'b0111, 1'b1, 3'd1);
    snap_pix(10'd298, 10'd357, 4'b0111, 1'b1, 3'd1);
    snap_pix(10'd300, 10'd362, 4'b0111, 1'b0, 3'd0);
    snap_pix(10'd302, 10'd392, 4'b0111, 1'b1, 3'd2);
    snap_pix(10'd303, 10'd392, 4'b0111, 1'b0, 3'd0);

    // Fill the pool, refuse when full, hit frees slot 2 for reuse
    tick(3);
    fire(1'b1);
    snap(4'b1111, 3, 10'd300, 10'd392);
    tick(3);
    snap(4'b1111, 0, 10'd300, 10'd260);
    fire(1'b0);
    hit = 4'b0100;
    cyc();
    hit = 4'b0000;
    snap(4'b1011, 2, 10'd300, 10'd601);
    fire(1'b1);
    snap(4'b1111, 2, 10'd300, 10'd392);

    // All hits land on the same cycle as a frame tick
    frame_clk = 1'b1;
    cyc();
    frame_clk = 1'b0;
    hit = 4'b1111;
    cyc();
    hit = 4'b0000;
    cyc();
    snap(4'b0000, 0, 10'd300, 10'd601);
    snap(4'b0000, 3, 10'd300, 10'd601);

    // Leftward bullet retires once x drops below X_MIN
    do_reset();
    Ball_X = 10'd170; Ball_Y = 10'd400; Ball_Size = 10'd8; direction = 3'd1;
    fire(1'b1);
    snap(4'b0001, 0, 10'd170, 10'd392);
    tick();
    snap(4'b0001, 0, 10'd166, 10'd381);
    tick();
    snap(4'b0001, 0, 10'd162, 10'd370);
    tick();
    snap(4'b0000, 0, 10'd158, 10'd359);

    // Rightward bullet retires once x exceeds X_MAX
    Ball_X = 10'd470; direction = 3'd3;
    fire(1'b1);
    tick();
    snap(4'b0001, 0, 10'd474, 10'd381);
    tick(2);
    snap(4'b0000, 0, 10'd482, 10'd359);

    // Upward wrap past zero retires the bullet
    tick(1);
    Ball_X = 10'd300; Ball_Y = 10'd13; direction = 3'd0;
    fire(1'b1);
    snap(4'b0001, 0, 10'd300, 10'd5);
    tick();
    snap(4'b0000, 0, 10'd300, 10'd1018);

    // Two co-located bullets: lowest index reported, then the next after a hit
    do_reset();
    Ball_Y = 10'd400;
    fire(1'b1);
    tick(3);
    Ball_Y = 10'd367;
    fire(1'b1);
    snap(4'b0011, 1, 10'd300, 10'd359);
    snap_pix(10'd301, 10'd358, 4'b0011, 1'b1, 3'd0);
    hit = 4'b0001;
    cyc();
    hit = 4'b0000;
    snap_pix(10'd301, 10'd358, 4'b0010, 1'b1, 3'd1);

    // Reset mid-flight with shoot held: everything cleared, no pulses
    Reset = 1'b1;
    shoot = 1'b1;
    cyc(2);
    Reset = 1'b0;
    shoot = 1'b0;
    cyc();
    snap_pix(10'd0, 10'd0, 4'b0000, 1'b0, 3'd0);
    snap(4'b0000, 1, 10'd0, 10'd0);

    cyc(4);
    if (ev_q.size() != 0) begin
      n_vec += ev_q.size();
      n_bad += ev_q.size();
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", ev_q.size());
    end
    if (snap_q.size() != 0) begin
      n_vec += snap_q.size();
      n_bad += snap_q.size();
      $display("FAIL missing_snapshots: %0d left, required 0", snap_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
